// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: width-parametrised pipeline stage register with a
// valid/ready handshake, synchronous flush and NOP bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid register. This makes
// up_ready purely registered and gives the stage a capacity of two words.
// Without the macro the stage holds one word and up_ready is combinational.
module pipe_stage_reg #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] NOP_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          dn_valid_reg, dn_valid_next;
  logic [DW-1:0] dn_data_reg, dn_data_next;
  logic          up_xfer;
  // The main register can take a new word: it is empty, or its word leaves now.
  logic          main_free;

  assign up_xfer   = up_valid & up_ready;
  assign main_free = !dn_valid_reg | dn_ready;
  assign dn_valid  = dn_valid_reg;
  assign dn_data   = dn_data_reg;

`ifdef PIPE_STAGE_SKID_EN

  logic          skid_valid_reg, skid_valid_next;
  logic [DW-1:0] skid_data_reg, skid_data_next;

  // Registered ready: accept whenever the skid slot is free.
  assign up_ready = !skid_valid_reg;

  // Next-state for the main and skid entries. Flush overrides everything.
  always_comb begin
    dn_valid_next   = dn_valid_reg;
    dn_data_next    = dn_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      dn_valid_next   = 1'b0;
      dn_data_next    = NOP_VAL;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        // The skid word is older than anything upstream, so it goes first.
        // up_ready is low here, so no new word can arrive this cycle.
        dn_valid_next   = 1'b1;
        dn_data_next    = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (up_xfer) begin
        dn_valid_next = 1'b1;
        dn_data_next  = up_data;
      end else begin
        dn_valid_next = 1'b0;
        dn_data_next  = NOP_VAL;
      end
    end else if (up_xfer) begin
      // Main is stalled: park the incoming word in the skid entry.
      skid_valid_next = 1'b1;
      skid_data_next  = up_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid_reg   <= 1'b0;
      dn_data_reg    <= NOP_VAL;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= NOP_VAL;
    end else begin
      dn_valid_reg   <= dn_valid_next;
      dn_data_reg    <= dn_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

`else

  // Combinational ready: accept when the held word is absent or leaving.
  assign up_ready = main_free;

  // Next-state for the single entry. Flush overrides everything.
  always_comb begin
    dn_valid_next = dn_valid_reg;
    dn_data_next  = dn_data_reg;
    if (flush) begin
      dn_valid_next = 1'b0;
      dn_data_next  = NOP_VAL;
    end else if (main_free) begin
      if (up_xfer) begin
        dn_valid_next = 1'b1;
        dn_data_next  = up_data;
      end else begin
        dn_valid_next = 1'b0;
        dn_data_next  = NOP_VAL;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid_reg <= 1'b0;
      dn_data_reg  <= NOP_VAL;
    end else begin
      dn_valid_reg <= dn_valid_next;
      dn_data_reg  <= dn_data_next;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks for pipe_stage_reg; works for both the
// default build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;
  localparam int            DW  = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [DW-1:0] up_data, dn_data;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DW(DW), .NOP_VAL(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_data  (dn_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h", tag, got);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_word, prev_data;
  logic          prev_stall;
  int            budget;

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;

    // Reset
    tick(); tick();
    check("rst_dn_valid", dn_valid, 0);
    check("rst_dn_data", dn_data, NOP);
    rst = 1'b0;
    tick();
    check("rst_up_ready", up_ready, 1);

    // Back-to-back flow, one cycle latency
    dn_ready = 1'b1; up_valid = 1'b1;
    up_data = 32'h1; tick();
    check("b2b_v1", dn_valid, 1);
    check("b2b_d1", dn_data, 32'h1);
    up_data = 32'h2; tick();
    check("b2b_v2", dn_valid, 1);
    check("b2b_d2", dn_data, 32'h2);
    up_data = 32'h3; tick();
    check("b2b_v3", dn_valid, 1);
    check("b2b_d3", dn_data, 32'h3);

    // Drain: bubble after last transfer
    up_valid = 1'b0; tick();
    check("drain_v", dn_valid, 0);
    check("drain_d", dn_data, NOP);

    // Stall with a held word
    up_valid = 1'b1; up_data = 32'hA5; dn_ready = 1'b0; tick();
    check("stall_load_d", dn_data, 32'hA5);
    up_data = 32'hB6; #1;
`ifdef PIPE_STAGE_SKID_EN
    check("stall_up_ready_skid", up_ready, 1);
    tick();
    check("skid_full_up_ready", up_ready, 0);
`else
    check("stall_up_ready", up_ready, 0);
    tick();
`endif
    up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_v", dn_valid, 1);
      check("stall_hold_d", dn_data, 32'hA5);
    end
    dn_ready = 1'b1; #1;
    check("stall_release_d", dn_data, 32'hA5);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    check("skid_out_v", dn_valid, 1);
    check("skid_out_d", dn_data, 32'hB6);
    check("skid_out_up_ready", up_ready, 1);
    tick();
`endif
    check("after_stall_v", dn_valid, 0);
    check("after_stall_d", dn_data, NOP);

    // Flush with the stage (and skid) full, offering 0xCC in the flush cycle
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h11; tick();
`ifdef PIPE_STAGE_SKID_EN
    up_data = 32'h22; tick();
`endif
    dn_ready = 1'b1; up_data = 32'hCC; flush = 1'b1; tick();
    flush = 1'b0; up_valid = 1'b0;
    check("flush_v", dn_valid, 0);
    check("flush_d", dn_data, NOP);
    check("flush_up_ready", up_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_cc_v", dn_valid, 0);
      check("flush_no_cc_d", dn_data, NOP);
    end

    // Random traffic against a scoreboard
    prev_stall = 1'b0; prev_data = '0;
    for (int n = 0; n < 300; n++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 2) != 0);
      up_data  = $urandom;
      #1;
      if (prev_stall) check("rnd_stable", dn_data, prev_data);
      if (!dn_valid) check("rnd_bubble", dn_data, NOP);
      if (dn_valid && dn_ready) begin
        if (sb_q.size() == 0) check("rnd_unexpected_word", 1, 0);
        else begin
          exp_word = sb_q.pop_front();
          check("rnd_order", dn_data, exp_word);
        end
      end
      if (up_valid && up_ready) sb_q.push_back(up_data);
      prev_stall = dn_valid & !dn_ready;
      prev_data  = dn_data;
      tick();
    end

    // Drain the scoreboard under a cycle budget
    up_valid = 1'b0; dn_ready = 1'b1;
    budget = 20;
    #1;
    while ((sb_q.size() != 0 || dn_valid) && budget > 0) begin
      if (dn_valid) begin
        if (sb_q.size() == 0) check("final_unexpected_word", 1, 0);
        else begin
          exp_word = sb_q.pop_front();
          check("final_order", dn_data, exp_word);
        end
      end
      tick();
      budget--;
    end
    check("final_timeout", (budget > 0) ? 1 : 0, 1);
    check("final_left", sb_q.size(), 0);
    check("final_v", dn_valid, 0);
    check("final_d", dn_data, NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
